// File: rtl/indicator_arbiter.sv
// -----------------------------------------------------------------------------
// indicator_arbiter
//
// Shares the single handlebar alert LED between three alert sources:
// overspeed, lap-complete and low-battery. Each source has its own on/off
// blink pattern. A fixed-priority arbiter (overspeed > lap > low battery)
// picks the source, and one 12-bit cycle counter times the ON and OFF phases
// of the granted pattern.
//
// Ports:
//   clk         system tick clock, 2.048 kHz
//   reset_n     asynchronous active-low reset
//   kmh         current speed, unsigned km/h (7 bits)
//   lap_pulse   one-cycle lap-complete event
//   low_bat     battery-low level
//   blink       registered LED drive
//   active_src  registered granted source: 00 none, 01 overspeed,
//               10 lap, 11 low battery
//   lap_done    one-cycle pulse when a full lap flash sequence finishes
// -----------------------------------------------------------------------------
module indicator_arbiter #(
  parameter int SPEED_LIMIT = 65,
  parameter int OS_ON       = 1024,
  parameter int OS_OFF      = 2048,
  parameter int LAP_ON      = 256,
  parameter int LAP_OFF     = 256,
  parameter int LAP_FLASHES = 3,
  parameter int BAT_ON      = 128,
  parameter int BAT_OFF     = 3968
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] kmh,
  input  logic       lap_pulse,
  input  logic       low_bat,
  output logic       blink,
  output logic [1:0] active_src,
  output logic       lap_done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    OFF  = 2'b10
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_OS   = 2'b01;
  localparam logic [1:0] SRC_LAP  = 2'b10;
  localparam logic [1:0] SRC_BAT  = 2'b11;

  // Phases end when the counter reaches length-1; a length of 4096 wraps to
  // 4095, which still fits the 12-bit counter.
  localparam logic [11:0] OS_ON_LAST   = 12'(OS_ON - 1);
  localparam logic [11:0] OS_OFF_LAST  = 12'(OS_OFF - 1);
  localparam logic [11:0] LAP_ON_LAST  = 12'(LAP_ON - 1);
  localparam logic [11:0] LAP_OFF_LAST = 12'(LAP_OFF - 1);
  localparam logic [11:0] BAT_ON_LAST  = 12'(BAT_ON - 1);
  localparam logic [11:0] BAT_OFF_LAST = 12'(BAT_OFF - 1);

  localparam logic [1:0]  LAST_FLASH   = 2'(LAP_FLASHES - 1);
  localparam logic [6:0]  SPEED_MAX    = 7'(SPEED_LIMIT);

  state_t      state_q, state_d;
  logic [11:0] counter_q, counter_d;
  logic [1:0]  flash_cnt_q, flash_cnt_d;
  logic        lap_pending_q, lap_pending_d;
  logic        blink_q, blink_d;
  logic [1:0]  src_q, src_d;
  logic        lap_done_q, lap_done_d;

  logic        os_req;
  logic        bat_req;
  logic        lap_clear;
  logic [1:0]  best_src;
  logic [11:0] on_last;
  logic [11:0] off_last;

  assign os_req  = (kmh > SPEED_MAX);
  assign bat_req = low_bat;

  // Highest-priority source currently requesting the LED.
  always_comb begin
    best_src = SRC_NONE;
    if (os_req) begin
      best_src = SRC_OS;
    end else if (lap_pending_q) begin
      best_src = SRC_LAP;
    end else if (bat_req) begin
      best_src = SRC_BAT;
    end
  end

  // Phase lengths of whichever pattern is currently granted.
  always_comb begin
    on_last  = 12'd0;
    off_last = 12'd0;
    unique case (src_q)
      SRC_OS: begin
        on_last  = OS_ON_LAST;
        off_last = OS_OFF_LAST;
      end
      SRC_LAP: begin
        on_last  = LAP_ON_LAST;
        off_last = LAP_OFF_LAST;
      end
      SRC_BAT: begin
        on_last  = BAT_ON_LAST;
        off_last = BAT_OFF_LAST;
      end
      default: begin
        on_last  = 12'd0;
        off_last = 12'd0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    flash_cnt_d = flash_cnt_q;
    blink_d     = blink_q;
    src_d       = src_q;
    lap_done_d  = 1'b0;
    lap_clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        blink_d = 1'b0;
        src_d   = SRC_NONE;
        if (best_src != SRC_NONE) begin
          state_d     = ON;
          blink_d     = 1'b1;
          counter_d   = 12'd0;
          src_d       = best_src;
          flash_cnt_d = 2'd0;
          lap_clear   = (best_src == SRC_LAP);
        end
      end

      ON, OFF: begin
        if (src_q == SRC_BAT && os_req) begin
          // Overspeed cuts into a low-battery pattern at any cycle.
          state_d   = ON;
          blink_d   = 1'b1;
          counter_d = 12'd0;
          src_d     = SRC_OS;
        end else if ((src_q == SRC_OS && !os_req) ||
                     (src_q == SRC_BAT && !bat_req)) begin
          // Level source went away: go dark and re-arbitrate from IDLE.
          state_d   = IDLE;
          blink_d   = 1'b0;
          counter_d = 12'd0;
          src_d     = SRC_NONE;
        end else if (state_q == ON) begin
          if (counter_q == on_last) begin
            state_d   = OFF;
            blink_d   = 1'b0;
            counter_d = 12'd0;
          end else begin
            counter_d = counter_q + 12'd1;
          end
        end else if (counter_q != off_last) begin
          counter_d = counter_q + 12'd1;
        end else if (src_q == SRC_LAP && flash_cnt_q < LAST_FLASH) begin
          // Lap sequence is atomic: keep flashing until the last flash.
          state_d     = ON;
          blink_d     = 1'b1;
          counter_d   = 12'd0;
          flash_cnt_d = flash_cnt_q + 2'd1;
        end else begin
          // End of period: re-arbitrate with no idle gap.
          if (src_q == SRC_LAP) begin
            lap_done_d  = 1'b1;
            flash_cnt_d = 2'd0;
          end
          counter_d = 12'd0;
          if (best_src != SRC_NONE) begin
            state_d   = ON;
            blink_d   = 1'b1;
            src_d     = best_src;
            lap_clear = (best_src == SRC_LAP);
          end else begin
            state_d = IDLE;
            blink_d = 1'b0;
            src_d   = SRC_NONE;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        blink_d   = 1'b0;
        counter_d = 12'd0;
        src_d     = SRC_NONE;
      end
    endcase
  end

  // A new lap_pulse wins over the clear from a grant in the same cycle, so a
  // pulse arriving exactly at grant time queues one more sequence.
  assign lap_pending_d = lap_pulse | (lap_pending_q & ~lap_clear);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      counter_q     <= 12'd0;
      flash_cnt_q   <= 2'd0;
      lap_pending_q <= 1'b0;
      blink_q       <= 1'b0;
      src_q         <= SRC_NONE;
      lap_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      flash_cnt_q   <= flash_cnt_d;
      lap_pending_q <= lap_pending_d;
      blink_q       <= blink_d;
      src_q         <= src_d;
      lap_done_q    <= lap_done_d;
    end
  end

  assign blink      = blink_q;
  assign active_src = src_q;
  assign lap_done   = lap_done_q;

endmodule

// File: tb/tb_indicator_arbiter.sv
// -----------------------------------------------------------------------------
// tb_indicator_arbiter
//
// Self-checking bench for indicator_arbiter. A table of timed vectors walks
// the main patterns, hand-written sequences cover lap atomicity, queueing and
// asynchronous reset, and a randomized phase compares every cycle against a
// behavioural model that tracks "which source, how far into its period".
// -----------------------------------------------------------------------------
module tb_indicator_arbiter;

  localparam int LIMIT    = 65;
  localparam int OS_ON_L  = 1024;
  localparam int OS_OFF_L = 2048;
  localparam int LAP_ON_L = 256;
  localparam int LAP_OFF_L= 256;
  localparam int FLASHES  = 3;
  localparam int BAT_ON_L = 128;
  localparam int BAT_OFF_L= 3968;

  logic       clk;
  logic       reset_n;
  logic [6:0] kmh;
  logic       lap_pulse;
  logic       low_bat;
  logic       blink;
  logic [1:0] active_src;
  logic       lap_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural model state: granted source (0 none,1 os,2 lap,3 bat),
  // position inside the current on+off period, flash index, queued lap.
  int m_src;
  int m_pos;
  int m_flash;
  bit m_pend;
  bit m_done;

  typedef struct {
    int       kmh;
    bit       lap;
    bit       bat;
    int       hold;
    bit       eb;
    bit [1:0] es;
    bit       ed;
    string    name;
  } vec_t;

  vec_t vecs[$];

  indicator_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .kmh        (kmh),
    .lap_pulse  (lap_pulse),
    .low_bat    (low_bat),
    .blink      (blink),
    .active_src (active_src),
    .lap_done   (lap_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int on_len(int s);
    case (s)
      1: return OS_ON_L;
      2: return LAP_ON_L;
      3: return BAT_ON_L;
      default: return 0;
    endcase
  endfunction

  function automatic int period(int s);
    case (s)
      1: return OS_ON_L + OS_OFF_L;
      2: return LAP_ON_L + LAP_OFF_L;
      3: return BAT_ON_L + BAT_OFF_L;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_src = 0;
    m_pos = 0;
    m_flash = 0;
    m_pend = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input int k, input bit lp, input bit lb);
    bit os;
    bit clr;
    int pick;
    os = (k > LIMIT);
    clr = 1'b0;
    m_done = 1'b0;
    pick = os ? 1 : (m_pend ? 2 : (lb ? 3 : 0));
    if (m_src == 0) begin
      if (pick != 0) begin
        m_src = pick;
        m_pos = 0;
        m_flash = 0;
        clr = (pick == 2);
      end
    end else if (m_src == 3 && os) begin
      m_src = 1;
      m_pos = 0;
    end else if ((m_src == 1 && !os) || (m_src == 3 && !lb)) begin
      m_src = 0;
      m_pos = 0;
    end else if (m_pos == period(m_src) - 1) begin
      if (m_src == 2 && m_flash < FLASHES - 1) begin
        m_flash++;
        m_pos = 0;
      end else begin
        if (m_src == 2) begin
          m_done = 1'b1;
          m_flash = 0;
        end
        m_src = pick;
        m_pos = 0;
        clr = (pick == 2);
      end
    end else begin
      m_pos++;
    end
    m_pend = lp ? 1'b1 : (clr ? 1'b0 : m_pend);
  endtask

  task automatic checkOutput(input string name, input bit eb, input bit [1:0] es, input bit ed);
    total_cnt++;
    if ({blink, active_src, lap_done} === {eb, es, ed}) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s at %0t: blink/src/done got %b/%b/%b expected %b/%b/%b",
               name, $time, blink, active_src, lap_done, eb, es, ed);
    end
  endtask

  // One clock edge; the model advances on the same inputs and is compared.
  task automatic tick();
    bit [1:0] ms;
    @(posedge clk);
    #1;
    model_step(int'(kmh), lap_pulse, low_bat);
    ms = 2'(m_src);
    checkOutput("model", (m_src != 0) && (m_pos < on_len(m_src)), ms, m_done);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    kmh = 7'(v.kmh);
    low_bat = v.bat;
    lap_pulse = v.lap;
    for (int i = 0; i < v.hold; i++) begin
      tick();
      lap_pulse = 1'b0;
    end
    checkOutput(v.name, v.eb, v.es, v.ed);
  endtask

  initial begin
    reset_n = 1'b0;
    kmh = 7'd0;
    lap_pulse = 1'b0;
    low_bat = 1'b0;
    model_reset();

    vecs.push_back('{66, 1'b0, 1'b0, 1,    1'b1, 2'b01, 1'b0, "os_first_edge"});
    vecs.push_back('{66, 1'b0, 1'b0, 1023, 1'b1, 2'b01, 1'b0, "os_on_last"});
    vecs.push_back('{66, 1'b0, 1'b0, 1,    1'b0, 2'b01, 1'b0, "os_off_start"});
    vecs.push_back('{66, 1'b0, 1'b0, 2047, 1'b0, 2'b01, 1'b0, "os_off_last"});
    vecs.push_back('{66, 1'b0, 1'b0, 1,    1'b1, 2'b01, 1'b0, "os_second_on"});
    vecs.push_back('{65, 1'b0, 1'b0, 1,    1'b0, 2'b00, 1'b0, "limit_drop"});
    vecs.push_back('{65, 1'b0, 1'b0, 500,  1'b0, 2'b00, 1'b0, "limit_idle"});
    vecs.push_back('{66, 1'b0, 1'b0, 1,    1'b1, 2'b01, 1'b0, "edge_65_66"});
    vecs.push_back('{0,  1'b0, 1'b0, 1,    1'b0, 2'b00, 1'b0, "speed_drop"});
    vecs.push_back('{0,  1'b1, 1'b0, 1,    1'b0, 2'b00, 1'b0, "lap_pending"});
    vecs.push_back('{0,  1'b0, 1'b0, 1,    1'b1, 2'b10, 1'b0, "lap_grant"});
    vecs.push_back('{0,  1'b0, 1'b0, 255,  1'b1, 2'b10, 1'b0, "lap_on1_last"});
    vecs.push_back('{0,  1'b0, 1'b0, 1,    1'b0, 2'b10, 1'b0, "lap_off1"});
    vecs.push_back('{0,  1'b0, 1'b0, 256,  1'b1, 2'b10, 1'b0, "lap_on2"});
    vecs.push_back('{0,  1'b0, 1'b0, 1023, 1'b0, 2'b10, 1'b0, "lap_off3_last"});
    vecs.push_back('{0,  1'b0, 1'b0, 1,    1'b0, 2'b00, 1'b1, "lap_done"});
    vecs.push_back('{0,  1'b0, 1'b0, 1,    1'b0, 2'b00, 1'b0, "lap_done_once"});
    vecs.push_back('{0,  1'b0, 1'b1, 1,    1'b1, 2'b11, 1'b0, "bat_grant"});
    vecs.push_back('{0,  1'b0, 1'b1, 50,   1'b1, 2'b11, 1'b0, "bat_on_mid"});
    vecs.push_back('{70, 1'b0, 1'b1, 1,    1'b1, 2'b01, 1'b0, "os_preempt"});
    vecs.push_back('{70, 1'b0, 1'b1, 1023, 1'b1, 2'b01, 1'b0, "os_restart_on"});
    vecs.push_back('{70, 1'b0, 1'b1, 1,    1'b0, 2'b01, 1'b0, "os_restart_off"});
    vecs.push_back('{60, 1'b0, 1'b1, 1,    1'b0, 2'b00, 1'b0, "os_drop_idle"});
    vecs.push_back('{60, 1'b0, 1'b1, 1,    1'b1, 2'b11, 1'b0, "bat_resume"});
    vecs.push_back('{60, 1'b0, 1'b1, 127,  1'b1, 2'b11, 1'b0, "bat_on_last"});
    vecs.push_back('{60, 1'b0, 1'b1, 1,    1'b0, 2'b11, 1'b0, "bat_off"});
    vecs.push_back('{60, 1'b0, 1'b0, 1,    1'b0, 2'b00, 1'b0, "bat_drop"});

    checkOutput("reset_state", 1'b0, 2'b00, 1'b0);
    kmh = 7'd66;
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Lap sequence with a pulse coincident with its grant, overspeed arriving
    // during flash 2, then a second queued sequence and a single-slot queue.
    kmh = 7'd0;
    low_bat = 1'b0;
    lap_pulse = 1'b1;
    tick();
    tick();
    lap_pulse = 1'b0;
    checkOutput("lapA_grant", 1'b1, 2'b10, 1'b0);
    repeat (600) tick();
    kmh = 7'd70;
    repeat (935) tick();
    checkOutput("lapA_atomic", 1'b0, 2'b10, 1'b0);
    tick();
    checkOutput("lapA_os_no_gap", 1'b1, 2'b01, 1'b1);
    kmh = 7'd0;
    tick();
    checkOutput("lapA_os_drop", 1'b0, 2'b00, 1'b0);
    tick();
    checkOutput("lapB_grant", 1'b1, 2'b10, 1'b0);
    repeat (100) tick();
    lap_pulse = 1'b1;
    tick();
    lap_pulse = 1'b0;
    repeat (10) tick();
    lap_pulse = 1'b1;
    tick();
    lap_pulse = 1'b0;
    repeat (1424) tick();
    checkOutput("lapC_back_to_back", 1'b1, 2'b10, 1'b1);
    repeat (1536) tick();
    checkOutput("lapC_single_queue", 1'b0, 2'b00, 1'b1);
    tick();
    checkOutput("lapC_idle", 1'b0, 2'b00, 1'b0);

    // Asynchronous reset in the middle of an overspeed OFF phase with a lap
    // queued behind it.
    kmh = 7'd66;
    do_reset();
    repeat (1050) tick();
    lap_pulse = 1'b1;
    tick();
    lap_pulse = 1'b0;
    repeat (49) tick();
    checkOutput("rst_pre_off", 1'b0, 2'b01, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async", 1'b0, 2'b00, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    checkOutput("rst_restart_on", 1'b1, 2'b01, 1'b0);
    repeat (1023) tick();
    checkOutput("rst_on_last", 1'b1, 2'b01, 1'b0);
    tick();
    checkOutput("rst_restart_off", 1'b0, 2'b01, 1'b0);
    kmh = 7'd0;
    tick();
    checkOutput("rst_drop", 1'b0, 2'b00, 1'b0);
    repeat (5) tick();
    checkOutput("rst_pending_cleared", 1'b0, 2'b00, 1'b0);

    // Randomized run checked cycle by cycle against the model.
    kmh = 7'd0;
    low_bat = 1'b0;
    do_reset();
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 1199) == 0) kmh = 7'($urandom_range(60, 72));
      if ($urandom_range(0, 2999) == 0) low_bat = ~low_bat;
      lap_pulse = ($urandom_range(0, 1499) == 0);
      tick();
    end
    lap_pulse = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
